// File: rtl/clkdiv_ramp.sv
// clkdiv_ramp: steps a programmable clock divider's ratio toward a requested
// target one bounded step at a time. After each step it waits for the divider
// to signal the transition (div_busy high, then low) and then dwells a number
// of divider output periods, so downstream clocks never see a large jump.
//
// Optional build macro: CLKDIV_RAMP_ABORT_EN adds an 'abort' input that ends
// a ramp early, holding the ratio reached so far.
module clkdiv_ramp #(
    parameter int n        = 4,   // ratio width
    parameter int STEP     = 1,   // largest ratio change per step
    parameter int DWELL    = 4,   // output periods held per ratio (>= 1)
    parameter int TMO      = 16,  // cycles allowed for div_busy to rise
    parameter int DIV_INIT = 0    // ratio after reset (0 = output disabled)
) (
    input  logic         clk,
    input  logic         reset,
`ifdef CLKDIV_RAMP_ABORT_EN
    input  logic         abort,
`endif
    input  logic [n-1:0] target,
    input  logic         start,
    output logic [n-1:0] div,
    input  logic         div_busy,
    input  logic         div_clk,
    output logic         busy,
    output logic         done,
    output logic         timeout
);

    // One counter serves both the settle timeout and the dwell count.
    localparam int              CNT_MAX    = (TMO > DWELL) ? TMO : DWELL;
    localparam int              CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   TMO_LAST   = CW'(TMO - 1);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [n-1:0]    DIV_RST    = n'(DIV_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE_HI,
        S_SETTLE_LO,
        S_DWELL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [n-1:0]    r_div;
    logic [n-1:0]    r_target;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;
    logic            r_pending;   // start seen during DONE, served from IDLE
    logic            r_div_clk_q;

    logic [n-1:0]    w_tgt;
    logic            w_up;
    logic [n-1:0]    w_dist;
    logic [n-1:0]    w_step_sz;
    logic [n-1:0]    w_next_div;
    logic            w_edge;
    logic            w_tick;
    logic            w_ramping;
    logic            w_abort;

    // A start arriving this cycle retargets immediately, so every decision
    // made this cycle already uses the new target.
    assign w_tgt      = start ? target : r_target;
    assign w_up       = (w_tgt > r_div);
    assign w_dist     = w_up ? (w_tgt - r_div) : (r_div - w_tgt);
    // Clamping the step to the remaining distance rules out overshoot and wrap.
    assign w_step_sz  = (int'(w_dist) > STEP) ? n'(STEP) : w_dist;
    assign w_next_div = w_up ? (r_div + w_step_sz) : (r_div - w_step_sz);

    // Ratio 0 has no output and ratio 1 is a passthrough, so clk cycles are
    // counted instead of div_clk edges there.
    assign w_edge     = div_clk & ~r_div_clk_q;
    assign w_tick     = (r_div <= n'(1)) | w_edge;

    assign w_ramping  = (r_state == S_STEP)      || (r_state == S_SETTLE_HI) ||
                        (r_state == S_SETTLE_LO) || (r_state == S_DWELL);

`ifdef CLKDIV_RAMP_ABORT_EN
    assign w_abort    = abort & w_ramping;
`else
    assign w_abort    = 1'b0;
`endif

    // Delayed div_clk sample for edge detection; kept running in every state
    // so the first dwell edge is never spurious.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        r_div_clk_q <= reset ? 1'b0 : div_clk;
    end

    // Ramp sequencer: state, ratio, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= DIV_RST;
            r_target  <= DIV_RST;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Freeze at the ratio reached; the DONE state reports it.
                r_target <= r_div;
                r_state  <= S_DONE;
            end else begin
                if (start && w_ramping) begin
                    r_target <= target;
                end
                case (r_state)
                    S_IDLE: begin
                        if (start || r_pending) begin
                            r_target  <= w_tgt;
                            r_timeout <= 1'b0;
                            r_busy    <= 1'b1;
                            r_pending <= 1'b0;
                            r_state   <= (w_tgt == r_div) ? S_DONE : S_STEP;
                        end
                    end
                    S_STEP: begin
                        r_div   <= w_next_div;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE_HI;
                    end
                    S_SETTLE_HI: begin
                        if (div_busy) begin
                            r_state <= S_SETTLE_LO;
                        end else if (r_cnt == TMO_LAST) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_DWELL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SETTLE_LO: begin
                        if (!div_busy) begin
                            r_cnt   <= '0;
                            r_state <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (w_tick) begin
                            if (r_cnt == DWELL_LAST) begin
                                r_cnt   <= '0;
                                r_state <= (w_tgt != r_div) ? S_STEP : S_DONE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (start) begin
                            r_target  <= target;
                            r_pending <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign div     = r_div;
    assign busy    = r_busy;
    assign done    = r_done;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_clkdiv_ramp.sv
// Testbench for clkdiv_ramp: two instances (STEP=1 and STEP=2) each driving
// a behavioural divider model; a per-instance scoreboard checks every ratio
// value the sequencer drives against values queued when stimulus is applied.
module tb_clkdiv_ramp;

    localparam int TMO      = 16;
    localparam int DWELL    = 4;
    localparam int BUSY_LEN = 4;
    localparam int BUDGET   = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] target0, target1, div0, div1;
    logic       start0, start1, busy0, busy1, done0, done1, tmo0, tmo1;
    logic       dbusy [2];
    logic       dclk  [2];
    bit         busy_en [2];
`ifdef CLKDIV_RAMP_ABORT_EN
    logic       abort0, abort1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clkdiv_ramp #(.n(4), .STEP(1), .DWELL(DWELL), .TMO(TMO), .DIV_INIT(0)) u_dut0 (
        .clk(clk), .reset(rst),
`ifdef CLKDIV_RAMP_ABORT_EN
        .abort(abort0),
`endif
        .target(target0), .start(start0), .div(div0), .div_busy(dbusy[0]),
        .div_clk(dclk[0]), .busy(busy0), .done(done0), .timeout(tmo0)
    );

    clkdiv_ramp #(.n(4), .STEP(2), .DWELL(DWELL), .TMO(TMO), .DIV_INIT(0)) u_dut1 (
        .clk(clk), .reset(rst),
`ifdef CLKDIV_RAMP_ABORT_EN
        .abort(abort1),
`endif
        .target(target1), .start(start1), .div(div1), .div_busy(dbusy[1]),
        .div_clk(dclk[1]), .busy(busy1), .done(done1), .timeout(tmo1)
    );

    // ---------------- divider model ----------------
    // On a ratio change: busy rises one cycle later for BUSY_LEN cycles (if
    // enabled) and the output counter restarts; output period = ratio.
    logic [3:0] mdiv [2] = '{4'd0, 4'd0};
    int         bcnt [2] = '{0, 0};
    int         ccnt [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] d;
            d = (i == 0) ? div0 : div1;
            if (d !== mdiv[i]) begin
                mdiv[i] <= d;
                bcnt[i] <= busy_en[i] ? BUSY_LEN : 0;
                ccnt[i] <= 0;
            end else begin
                if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
                ccnt[i] <= (ccnt[i] + 1 >= int'(d)) ? 0 : ccnt[i] + 1;
            end
        end
    end

    assign dbusy[0] = (bcnt[0] != 0);
    assign dbusy[1] = (bcnt[1] != 0);
    assign dclk[0]  = (mdiv[0] >= 4'd2) && (ccnt[0] >= int'(mdiv[0] / 4'd2));
    assign dclk[1]  = (mdiv[1] >= 4'd2) && (ccnt[1] >= int'(mdiv[1] / 4'd2));

    // ---------------- scoreboards / monitors ----------------
    logic [3:0] exp0 [$];
    logic [3:0] exp1 [$];
    logic [3:0] last0 = 4'd0, last1 = 4'd0;
    bit         mon_en = 1'b0;
    bit         hold_en = 1'b1;
    bit         hold_armed0 = 1'b0;
    int         hold0 = 0;
    int         done_cnt0 = 0, done_cnt1 = 0;

    function automatic int eff(input logic [3:0] d);
        return (d <= 4'd1) ? 1 : int'(d);
    endfunction

    // Instance 0: ratio sequence plus minimum hold time of each ratio.
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (done0 === 1'b1) begin
            done_cnt0++;
            if (hold_en && hold_armed0) begin
                n_checks++;
                if (hold0 < DWELL * eff(last0)) begin
                    n_fail++;
                    $display("FAIL hold0_final: div=%0d held %0d cycles, required >= %0d",
                             last0, hold0, DWELL * eff(last0));
                end
            end
            hold_armed0 = 1'b0;
        end
        if (!mon_en) begin
            last0 = div0;
        end else if (div0 !== last0) begin
            if (hold_en && hold_armed0 && busy0 === 1'b1) begin
                n_checks++;
                if (hold0 < DWELL * eff(last0)) begin
                    n_fail++;
                    $display("FAIL hold0: div=%0d held %0d cycles, required >= %0d",
                             last0, hold0, DWELL * eff(last0));
                end
            end
            n_checks++;
            if (exp0.size() == 0) begin
                n_fail++;
                $display("FAIL sb0_div: got div=%0d, required no change", div0);
            end else begin
                e = exp0.pop_front();
                if (div0 !== e) begin
                    n_fail++;
                    $display("FAIL sb0_div: got div=%0d, required %0d", div0, e);
                end
            end
            hold_armed0 = (busy0 === 1'b1);
            hold0 = 1;
            last0 = div0;
        end else begin
            hold0++;
        end
    end

    // Instance 1: ratio sequence only.
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (done1 === 1'b1) done_cnt1++;
        if (!mon_en) begin
            last1 = div1;
        end else if (div1 !== last1) begin
            n_checks++;
            if (exp1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_div: got div=%0d, required no change", div1);
            end else begin
                e = exp1.pop_front();
                if (div1 !== e) begin
                    n_fail++;
                    $display("FAIL sb1_div: got div=%0d, required %0d", div1, e);
                end
            end
            last1 = div1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input int inst, input logic [3:0] tgt);
        @(negedge clk);
        if (inst == 0) begin target0 = tgt; start0 = 1'b1; end
        else           begin target1 = tgt; start1 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (((inst == 0) ? done0 : done1) === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_div(input logic [3:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (div0 === v) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        if (div0 !== 4'd0) exp0.push_back(4'd0);
        if (div1 !== 4'd0) exp1.push_back(4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (div0 !== 4'd0)  begin n_fail++; $display("FAIL reset_div0: got %0d, required 0", div0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy0: got %b, required 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0: got %b, required 0", done0); end
        n_checks++; if (tmo0 !== 1'b0)  begin n_fail++; $display("FAIL reset_tmo0: got %b, required 0", tmo0); end
        n_checks++; if ({div1, busy1, done1, tmo1} !== 7'd0)
            begin n_fail++; $display("FAIL reset_inst1: got div=%0d busy=%b done=%b tmo=%b, required all 0", div1, busy1, done1, tmo1); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_zero_distance();
        @(negedge clk);
        target0 = 4'd0; start0 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy0 !== 1'b1 || done0 !== 1'b0)
            begin n_fail++; $display("FAIL zero_c1: got busy=%b done=%b, required busy=1 done=0", busy0, done0); end
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (done0 !== 1'b1 || busy0 !== 1'b0)
            begin n_fail++; $display("FAIL zero_c2: got done=%b busy=%b, required done=1 busy=0", done0, busy0); end
        n_checks++; if (div0 !== 4'd0 || tmo0 !== 1'b0)
            begin n_fail++; $display("FAIL zero_state: got div=%0d tmo=%b, required div=0 tmo=0", div0, tmo0); end
        @(posedge clk); #1;
        n_checks++; if (done0 !== 1'b0)
            begin n_fail++; $display("FAIL zero_c3: got done=%b, required 0 (single pulse)", done0); end
    endtask

    task automatic test_ramp_up();
        int  dc;
        int  busy_bad;
        bit  ok;
        dc = done_cnt0;
        busy_bad = 0;
        ok = 1'b0;
        for (int v = 1; v <= 5; v++) exp0.push_back(4'(v));
        pulse_start(0, 4'd5);
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin ok = 1'b1; break; end
            if (busy0 !== 1'b1) busy_bad++;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL up_done: no done within %0d cycles", BUDGET); end
        n_checks++; if (busy_bad != 0)
            begin n_fail++; $display("FAIL up_busy: busy low for %0d cycles mid-ramp, required 0", busy_bad); end
        n_checks++; if (div0 !== 4'd5) begin n_fail++; $display("FAIL up_final: got div=%0d, required 5", div0); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (done_cnt0 - dc != 1)
            begin n_fail++; $display("FAIL up_done_count: got %0d pulses, required 1", done_cnt0 - dc); end
        n_checks++; if (exp0.size() != 0)
            begin n_fail++; $display("FAIL up_queue: %0d ratios not driven, required 0", exp0.size()); end
    endtask

    task automatic test_ramp_down();
        bit ok;
        foreach (exp1[i]) exp1.delete(i);
        exp1.push_back(4'd2); exp1.push_back(4'd4); exp1.push_back(4'd6);
        exp1.push_back(4'd8); exp1.push_back(4'd9);
        pulse_start(1, 4'd9);
        wait_done(1, BUDGET, ok);
        n_checks++; if (!ok || div1 !== 4'd9)
            begin n_fail++; $display("FAIL down_prep: got done=%b div=%0d, required done=1 div=9", ok, div1); end
        exp1.push_back(4'd7); exp1.push_back(4'd5); exp1.push_back(4'd3); exp1.push_back(4'd2);
        pulse_start(1, 4'd2);
        wait_done(1, BUDGET, ok);
        n_checks++; if (!ok || div1 !== 4'd2)
            begin n_fail++; $display("FAIL down_final: got done=%b div=%0d, required done=1 div=2", ok, div1); end
        n_checks++; if (exp1.size() != 0)
            begin n_fail++; $display("FAIL down_queue: %0d ratios not driven, required 0", exp1.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        busy_en[0] = 1'b0;
        exp0.push_back(4'd6); exp0.push_back(4'd7);
        pulse_start(0, 4'd7);
        wait_div(4'd6, 50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_step: div never reached 6"); end
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            if (k == TMO - 1) begin
                n_checks++; if (tmo0 !== 1'b0)
                    begin n_fail++; $display("FAIL tmo_early: got timeout=%b at cycle %0d, required 0", tmo0, k); end
            end
            if (k == TMO) begin
                n_checks++; if (tmo0 !== 1'b1)
                    begin n_fail++; $display("FAIL tmo_set: got timeout=%b at cycle %0d, required 1", tmo0, k); end
            end
        end
        wait_done(0, BUDGET, ok);
        n_checks++; if (!ok || div0 !== 4'd7)
            begin n_fail++; $display("FAIL tmo_final: got done=%b div=%0d, required done=1 div=7", ok, div0); end
        busy_en[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (tmo0 !== 1'b1)
            begin n_fail++; $display("FAIL tmo_sticky: got timeout=%b, required 1", tmo0); end
        pulse_start(0, 4'd7);
        wait_done(0, 10, ok);
        n_checks++; if (!ok || tmo0 !== 1'b0)
            begin n_fail++; $display("FAIL tmo_clear: got done=%b timeout=%b, required done=1 timeout=0", ok, tmo0); end
    endtask

    task automatic test_retarget();
        bit ok;
        int dc;
        do_reset();
        dc = done_cnt0;
        for (int v = 1; v <= 8; v++) exp0.push_back(4'(v));
        pulse_start(0, 4'd8);
        wait_div(4'd5, BUDGET, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL retgt_reach: div never reached 5"); end
        @(negedge clk);
        foreach (exp0[i]) exp0.delete(i);
        exp0.push_back(4'd4); exp0.push_back(4'd3);
        target0 = 4'd3; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, BUDGET, ok);
        n_checks++; if (!ok || div0 !== 4'd3)
            begin n_fail++; $display("FAIL retgt_final: got done=%b div=%0d, required done=1 div=3", ok, div0); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (done_cnt0 - dc != 1 || exp0.size() != 0)
            begin n_fail++; $display("FAIL retgt_count: got %0d dones, %0d queued, required 1 and 0", done_cnt0 - dc, exp0.size()); end
    endtask

    task automatic test_reset_mid_ramp();
        bit ok;
        for (int v = 4; v <= 8; v++) exp0.push_back(4'(v));
        pulse_start(0, 4'd8);
        wait_div(4'd4, BUDGET, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach: div never reached 4"); end
        @(negedge clk);
        foreach (exp0[i]) exp0.delete(i);
        exp0.push_back(4'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (div0 !== 4'd0 || busy0 !== 1'b0 || done0 !== 1'b0)
            begin n_fail++; $display("FAIL rstmid: got div=%0d busy=%b done=%b, required 0 0 0", div0, busy0, done0); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

`ifdef CLKDIV_RAMP_ABORT_EN
    task automatic test_abort();
        bit ok;
        hold_en = 1'b0;
        for (int v = 1; v <= 4; v++) exp0.push_back(4'(v));
        pulse_start(0, 4'd8);
        wait_div(4'd4, BUDGET, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach: div never reached 4"); end
        @(negedge clk);
        abort0 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (done0 !== 1'b0)
            begin n_fail++; $display("FAIL abort_c1: got done=%b, required 0", done0); end
        @(negedge clk);
        abort0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (done0 !== 1'b1 || div0 !== 4'd4 || busy0 !== 1'b0)
            begin n_fail++; $display("FAIL abort_done: got done=%b div=%0d busy=%b, required 1 4 0", done0, div0, busy0); end
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (div0 !== 4'd4 || busy0 !== 1'b0)
            begin n_fail++; $display("FAIL abort_hold: got div=%0d busy=%b, required 4 0", div0, busy0); end
        hold_en = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        target0 = 4'd0; target1 = 4'd0;
        start0 = 1'b0;  start1 = 1'b0;
        busy_en[0] = 1'b1; busy_en[1] = 1'b1;
`ifdef CLKDIV_RAMP_ABORT_EN
        abort0 = 1'b0; abort1 = 1'b0;
`endif
        test_reset();
        test_zero_distance();
        test_ramp_up();
        test_ramp_down();
        test_timeout();
        test_retarget();
        test_reset_mid_ramp();
`ifdef CLKDIV_RAMP_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_ramp.md
Name: clkdiv_ramp

Overview:
- Sequencer for a programmable clock divider with a `div` input and `reset` (transition-busy) output, running on the same input clock.
- Walks the divider ratio from its current value to a requested target, one step at a time, so downstream clock consumers never see a large frequency jump.
- After each step it waits for the divider to complete its transition, then dwells a programmable number of output periods.
- Used for soft start/stop of clocks feeding power-sensitive or PLL-less logic.

Parameters:
- n, 4, width of divider ratio vectors.
- STEP, 1, maximum ratio change per step; final step clamps to target.
- DWELL, 4, output periods to hold each intermediate ratio (≥1).
- TMO, 16, clk cycles to wait for div_busy to assert after a step before flagging a timeout.
- DIV_INIT, 0, ratio driven on div after reset (0 = divider output disabled).

Ports:
- clk  in  1  clock; same net as the divider's input clock.
- reset  in  1  synchronous, active-high reset.
- target  in  n  requested final ratio, sampled when start=1.
- start  in  1  one-cycle request to ramp to target.
- div  out  n  ratio driven to the divider; registered.
- div_busy  in  1  divider's reset output (high while a ratio change is in progress).
- div_clk  in  1  divider output, sampled in clk domain for dwell counting.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when div==target and the final dwell has finished.
- timeout  out  1  sticky; set on any settle timeout; cleared by reset or by a new start.

Behaviour:
- All state changes on posedge clk; reset has priority over everything.
- Reset values: div=DIV_INIT, busy=0, done=0, timeout=0, state=IDLE, counters=0, latched target=DIV_INIT.
- States:
  - IDLE → on start: latch target, clear timeout, busy=1.
    - If target==div: go to DONE next cycle.
    - Otherwise go to STEP.
  - STEP (1 cycle): div moves toward target by min(STEP, |target−div|); go to SETTLE_HI.
    - Arithmetic is unsigned n-bit.
    - Never overshoot; never wrap past 0 or 2^n−1.
  - SETTLE_HI: wait for div_busy=1.
    - If not seen within TMO cycles (count starts on SETTLE_HI entry): set timeout and go to DWELL.
    - If seen: go to SETTLE_LO.
  - SETTLE_LO: wait for div_busy=0, with no timeout; then go to DWELL.
  - DWELL: count rising edges of div_clk, detected as div_clk & ~div_clk_q (1-register delayed sample).
    - If div ≤ 1, count clk cycles instead, because ratio 0 has no output and ratio 1 is an ungated passthrough.
    - After DWELL counts: go to STEP if div != latched target, else go to DONE.
  - DONE (1 cycle): done=1, busy=0; go to IDLE.
- Latency for one step: STEP 1 cycle + settle + dwell. Zero-distance request: done exactly 2 cycles after start.
- start while busy: the new target is latched immediately.
  - Takes effect at the next STEP evaluation, so the ramp may reverse direction.
  - The step in progress completes its settle and dwell first.
  - timeout is not cleared.
- start in the same cycle as DONE: the DONE pulse still issues; the new request is latched and processed from IDLE next cycle.
- Edge-detect register (div_clk_q) keeps running in all states so the first DWELL edge is not spurious.
- Reset mid-ramp: div returns to DIV_INIT immediately; the divider sequences that change itself.

Optional Feature:
- Macro: CLKDIV_RAMP_ABORT_EN.
- Defined: adds input `abort` (1 bit).
  - abort=1 in any state except IDLE/DONE forces DONE next cycle.
  - div holds its current value; latched target is set to current div.
  - done pulses normally.
  - abort in IDLE is ignored.
- Not defined: no abort port; ramps always run to completion unless reset.

Test Plan:
- Zero-distance: reset (div=0), start with target=0 → done pulse 2 cycles later, div stays 0, timeout=0.
- Ramp up: start target=5, STEP=1, DWELL=4, divider model behaving → div steps 1,2,3,4,5; each step holds ≥4 div_clk periods; done once; busy high throughout.
- Ramp down with STEP=2: from div=9 to target=2 → div sequence 7,5,3,2 (clamped last step), no value below 2.
- Timeout: divider model holding div_busy=0 → after TMO cycles in SETTLE_HI, timeout=1 and the ramp continues to target; timeout stays 1 until the next start.
- Retarget mid-ramp: ramp 0→8, start target=3 while div=5 → div goes 5,4,3; single done.
- Reset mid-ramp at div=4 → next cycle div=DIV_INIT, busy=0, done=0; with CLKDIV_RAMP_ABORT_EN defined, abort at div=4 → done next cycle with div=4.
